stream_decoder: RTL and testbench
=================================

Name: stream_decoder

Overview:
- Downstream of the bitstream activation stage; converts a unipolar stochastic bitstream (P(x=1) encodes the value) back into a binary count.
- Counts the 1s in x over a window of 2^WIDTH samples and presents the result with a one-cycle valid strobe.
- A programmable skip period discards pipeline-fill cycles after start. Used at network outputs and for bench-side scoring.

Parameters:
- WIDTH, 8: log2 of window length; window = 2^WIDTH samples.
- SKIP, 6: cycles ignored after start before sampling begins; 0 is legal.

Ports:
- clk  input  1  clock, rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- start  input  1  begin a conversion; honoured only in IDLE.
- continuous  input  1  at window end, 1 = immediately start the next window with no skip.
- abort  input  1  synchronous abandon of the current conversion.
- x  input  1  bitstream under measurement.
- busy  output  1  high while not IDLE.
- count  output  WIDTH+1  number of 1s in the last completed window, 0..2^WIDTH.
- valid  output  1  one-cycle pulse when count updates.

Behaviour:
- Reset (n_rst low, asynchronous): state IDLE, count=0, valid=0, busy=0, internal accumulator=0, window counter=0. Reset mid-conversion discards all progress; no valid is issued.
- States: IDLE, SKIPPING, COUNTING. busy is registered and equals (state != IDLE).
- IDLE: start=1 sampled at edge E0 moves to SKIPPING if SKIP>0, otherwise to COUNTING. The accumulator and window counter clear at E0.
- SKIPPING: x is ignored at edges E1..E_SKIP. At E_SKIP the block moves to COUNTING.
- COUNTING: x is sampled at edges E(SKIP+1)..E(SKIP+2^WIDTH), accumulator += x.
- Last sample edge E(SKIP+2^WIDTH):
  - count <= accumulator + x, the full window including the final sample.
  - valid=1 for exactly the following cycle.
  - The accumulator clears.
- Transition at the last sample edge:
  - continuous=1 at that edge: stay in COUNTING. The next window samples at the following 2^WIDTH edges with no skip, so back-to-back windows give valid every 2^WIDTH cycles.
  - continuous=0: go to IDLE. busy falls in the same cycle valid is high.
- Accumulator width is WIDTH+1. It must represent 2^WIDTH (all-ones stream) with no wrap or saturation.
- Window counter width is WIDTH. It wraps from 2^WIDTH-1 to 0 and marks the last sample edge.
- count holds its value between valid pulses and is never altered by skip, abort or start.
- start while busy is ignored, with no restart and no effect on count.
- abort=1 in SKIPPING or COUNTING: go to IDLE at that edge and clear the accumulator. No valid is issued and count keeps its previous value.
- abort in IDLE has no effect. abort and start together in IDLE: abort wins and the block stays IDLE.
- abort at the last sample edge: abort wins, with no valid and count unchanged.
- Latency with continuous=0: SKIP+2^WIDTH edges from the start edge to the edge that raises valid.

Test Plan (WIDTH=4, SKIP=2 unless noted):
- x held 1, start pulse at E0 -> valid high only in the cycle after E18, count=16, busy low from E18; count still 16 ten cycles later.
- x held 0 -> count=0 with valid after E18. Then x=1 during E1..E2 only -> still count=0, proving the skip.
- x alternating 1,0 from E3, continuous=1 -> valid after E18, E34, E50, each with count=8, busy never falls. Drop continuous before E50 -> IDLE after E50.
- start re-pulsed at E7 while busy -> ignored, valid still only after E18. abort at E10 -> busy low after E10, no valid, count retains the prior value.
- n_rst pulsed low asynchronously at mid-window E12 -> count=0, valid=0, busy=0 immediately. A fresh start gives a correct count=16 with x=1.
- SKIP=0, WIDTH=8, x from an LFSR compare with P=9/16 -> count within 144±16 after exactly 256 edges. x=1 throughout -> count=256 (no wrap of the 9-bit output).

Source files
------------

// File: rtl/stream_decoder.sv
// Stochastic bitstream decoder: counts the 1s on x over a 2^WIDTH-sample window
// after an optional skip period, then presents the total with a one-cycle valid strobe.
module stream_decoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SKIP  = 6
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             x,
  output logic             busy,
  output logic [WIDTH:0]   count,
  output logic             valid
);

  localparam int unsigned SkipW = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam logic [SkipW-1:0] SkipLast = SkipW'((SKIP > 0) ? SKIP - 1 : 0);
  localparam logic [WIDTH-1:0] WinLast  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StSkip,
    StCount
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] win_q, win_d;
  logic [SkipW-1:0] skip_q, skip_d;
  logic [WIDTH:0]   count_q, count_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   x_ext;

  assign x_ext = {{WIDTH{1'b0}}, x};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    win_d   = win_q;
    skip_d  = skip_q;
    count_d = count_q;
    valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        // abort outranks start even while idle
        if (start && !abort) begin
          acc_d   = '0;
          win_d   = '0;
          skip_d  = '0;
          state_d = (SKIP > 0) ? StSkip : StCount;
        end
      end
      StSkip: begin
        if (abort) begin
          acc_d   = '0;
          state_d = StIdle;
        end else if (skip_q == SkipLast) begin
          state_d = StCount;
        end else begin
          skip_d = skip_q + SkipW'(1);
        end
      end
      StCount: begin
        if (abort) begin
          acc_d   = '0;
          state_d = StIdle;
        end else begin
          win_d = win_q + WIDTH'(1);
          if (win_q == WinLast) begin
            // Final sample folds straight into the published count.
            count_d = acc_q + x_ext;
            valid_d = 1'b1;
            acc_d   = '0;
            if (!continuous) begin
              state_d = StIdle;
            end
          end else begin
            acc_d = acc_q + x_ext;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      win_q   <= '0;
      skip_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      win_q   <= win_d;
      skip_q  <= skip_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign count = count_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_stream_decoder.sv
// Self-checking bench for stream_decoder: an edge-count model checks the WIDTH=4/SKIP=2
// instance every cycle; a WIDTH=8/SKIP=0 instance is checked with directed expectations.
module tb_stream_decoder;

  localparam int Win = 16;
  localparam int Sk  = 2;

  logic       clk;
  logic       n_rst;
  logic       start, continuous, abort, x;
  logic       busy, valid;
  logic [4:0] count;

  logic       start2, x2, cont2, abort2;
  logic       busy2, valid2;
  logic [8:0] count2;

  int n_chk  = 0;
  int n_pass = 0;

  stream_decoder #(.WIDTH(4), .SKIP(2)) u_dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .continuous (continuous),
    .abort      (abort),
    .x          (x),
    .busy       (busy),
    .count      (count),
    .valid      (valid)
  );

  stream_decoder #(.WIDTH(8), .SKIP(0)) u_dut2 (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start2),
    .continuous (cont2),
    .abort      (abort2),
    .x          (x2),
    .busy       (busy2),
    .count      (count2),
    .valid      (valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs apply to the next rising edge; returns 2 time units after that edge.
  task automatic step(input bit st, input bit ct, input bit ab, input bit xv);
    start = st; continuous = ct; abort = ab; x = xv;
    @(posedge clk); #2;
  endtask

  task automatic step2(input bit st, input bit xv);
    start2 = st; x2 = xv;
    @(posedge clk); #2;
  endtask

  // Model: counts edges since the start edge; samples are edges Sk+1 .. Sk+Win.
  bit m_run, m_valid;
  int m_pos, m_sum, m_count;

  initial begin
    m_run = 0; m_valid = 0; m_pos = 0; m_sum = 0; m_count = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        m_run = 0; m_valid = 0; m_pos = 0; m_sum = 0; m_count = 0;
      end
      check("model_busy", int'(busy), int'(m_run));
      check("model_valid", int'(valid), int'(m_valid));
      check("model_count", int'(count), m_count);
      if (n_rst) begin
        m_valid = 0;
        if (!m_run) begin
          if (start && !abort) begin
            m_run = 1; m_pos = 0; m_sum = 0;
          end
        end else if (abort) begin
          m_run = 0; m_sum = 0;
        end else begin
          m_pos++;
          if (m_pos > Sk) m_sum += int'(x);
          if (m_pos == Sk + Win) begin
            m_count = m_sum; m_valid = 1; m_sum = 0;
            if (continuous) m_pos = Sk;
            else m_run = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] lfsr;
    bit         xv;
    int         tally;

    n_rst = 1'b0;
    start = 0; continuous = 0; abort = 0; x = 0;
    start2 = 0; x2 = 0; cont2 = 0; abort2 = 0;
    @(posedge clk); #1;
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_count", int'(count), 0);
    @(posedge clk); #2;
    n_rst = 1'b1;
    repeat (2) step(0, 0, 0, 0);

    // All-ones window
    step(1, 0, 0, 1);
    for (int n = 1; n <= 18; n++) step(0, 0, 0, 1);
    check("ones_valid", int'(valid), 1);
    check("ones_count", int'(count), 16);
    check("ones_busy", int'(busy), 0);
    repeat (10) step(0, 0, 0, 1);
    check("ones_hold_count", int'(count), 16);
    check("ones_hold_valid", int'(valid), 0);

    // x high only during the skip period
    step(1, 0, 0, 0);
    for (int n = 1; n <= 18; n++) step(0, 0, 0, (n <= 2));
    check("skip_valid", int'(valid), 1);
    check("skip_count", int'(count), 0);
    repeat (2) step(0, 0, 0, 0);

    // Continuous alternating windows, continuous dropped before the third end
    step(1, 1, 0, 0);
    for (int n = 1; n <= 50; n++) begin
      step(0, (n <= 34), 0, (n >= 3) && ((n - 3) % 2 == 0));
      if (n == 18 || n == 34 || n == 50) begin
        check("cont_valid", int'(valid), 1);
        check("cont_count", int'(count), 8);
        check("cont_busy", int'(busy), (n == 50) ? 0 : 1);
      end
    end
    repeat (2) step(0, 0, 0, 0);

    // start while busy is ignored
    step(1, 0, 0, 1);
    for (int n = 1; n <= 18; n++) begin
      step((n == 7), 0, 0, 1);
      if (n == 17) check("restart_novalid", int'(valid), 0);
    end
    check("restart_valid", int'(valid), 1);
    check("restart_count", int'(count), 16);
    step(0, 0, 0, 0);

    // abort mid-window
    step(1, 0, 0, 0);
    for (int n = 1; n <= 10; n++) step(0, 0, (n == 10), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_count", int'(count), 16);
    repeat (12) step(0, 0, 0, 0);
    check("abort_hold_count", int'(count), 16);

    // abort together with start in idle
    step(1, 0, 1, 1);
    check("abort_start_busy", int'(busy), 0);
    repeat (3) step(0, 0, 0, 0);

    // Asynchronous reset mid-window, then a clean conversion
    step(1, 0, 0, 1);
    for (int n = 1; n <= 12; n++) step(0, 0, 0, 1);
    n_rst = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(valid), 0);
    check("arst_count", int'(count), 0);
    step(0, 0, 0, 0);
    n_rst = 1'b1;
    step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    for (int n = 1; n <= 18; n++) step(0, 0, 0, 1);
    check("post_rst_valid", int'(valid), 1);
    check("post_rst_count", int'(count), 16);
    step(0, 0, 0, 0);

    // WIDTH=8, SKIP=0: LFSR stream compared against 144/256
    lfsr  = 8'h5A;
    tally = 0;
    step2(1, 0);
    for (int n = 1; n <= 256; n++) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      xv   = (lfsr < 8'd144);
      tally += int'(xv);
      step2(0, xv);
      if (n == 255) check("w8_early_valid", int'(valid2), 0);
    end
    check("w8_lfsr_valid", int'(valid2), 1);
    check("w8_lfsr_count", int'(count2), tally);
    check("w8_lfsr_range", int'((count2 >= 9'd128) && (count2 <= 9'd160)), 1);
    check("w8_lfsr_busy", int'(busy2), 0);
    step2(0, 0);

    // WIDTH=8 all ones: full-scale 256 with no wrap
    step2(1, 1);
    for (int n = 1; n <= 256; n++) step2(0, 1);
    check("w8_ones_valid", int'(valid2), 1);
    check("w8_ones_count", int'(count2), 256);
    step2(0, 0);
    check("w8_ones_hold", int'(count2), 256);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
